// File: rtl/eth_flat_frame_bridge.sv
// Bridge between a flat fixed-size Ethernet frame vector and the split
// Ethernet header + AXI-stream payload interface.
// TX: flat frame in -> header + payload beats out.
// RX: header + payload beats in -> flat frame out.
// Optional: define FLAT_FRAME_LEN_CHECK_EN to add m_frame_len_error.
module eth_flat_frame_bridge #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned PAYLOAD_BYTES = 28,
  parameter int unsigned FRAME_WIDTH   = 112 + 8 * PAYLOAD_BYTES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_frame_valid,
  output logic                   s_frame_ready,
  input  logic [FRAME_WIDTH-1:0] s_frame_data,
  output logic                   m_eth_hdr_valid,
  input  logic                   m_eth_hdr_ready,
  output logic [47:0]            m_eth_dest_mac,
  output logic [47:0]            m_eth_src_mac,
  output logic [15:0]            m_eth_type,
  output logic [DATA_WIDTH-1:0]  m_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0]  m_eth_payload_axis_tkeep,
  output logic                   m_eth_payload_axis_tvalid,
  input  logic                   m_eth_payload_axis_tready,
  output logic                   m_eth_payload_axis_tlast,
  output logic                   m_eth_payload_axis_tuser,
  input  logic                   s_eth_hdr_valid,
  output logic                   s_eth_hdr_ready,
  input  logic [47:0]            s_eth_dest_mac,
  input  logic [47:0]            s_eth_src_mac,
  input  logic [15:0]            s_eth_type,
  input  logic [DATA_WIDTH-1:0]  s_eth_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]  s_eth_payload_axis_tkeep,
  input  logic                   s_eth_payload_axis_tvalid,
  output logic                   s_eth_payload_axis_tready,
  input  logic                   s_eth_payload_axis_tlast,
  input  logic                   s_eth_payload_axis_tuser,
  output logic                   m_frame_valid,
  input  logic                   m_frame_ready,
  output logic [FRAME_WIDTH-1:0] m_frame_data,
  output logic                   m_frame_user
`ifdef FLAT_FRAME_LEN_CHECK_EN
  ,output logic                  m_frame_len_error
`endif
);

  localparam int unsigned PAY_W  = 8 * PAYLOAD_BYTES;
  localparam int unsigned BEATS  = (PAYLOAD_BYTES + KEEP_WIDTH - 1) / KEEP_WIDTH;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CNT_W  = $clog2(PAYLOAD_BYTES + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [0:0] {TX_IDLE, TX_SEND} tx_state_e;
  typedef enum logic [1:0] {RX_HDR, RX_PAYLOAD, RX_OUT} rx_state_e;

  tx_state_e              tx_state_q, tx_state_d;
  logic [FRAME_WIDTH-1:0] tx_frame_q, tx_frame_d;
  logic [BEAT_W-1:0]      tx_beat_q, tx_beat_d;
  logic                   tx_hdr_valid_q, tx_hdr_valid_d;
  logic                   tx_tvalid_q, tx_tvalid_d;
  logic                   tx_frame_ready_q, tx_frame_ready_d;
  logic                   tx_hdr_done_c, tx_pay_done_c;
  logic [DATA_WIDTH-1:0]  tx_tdata_c;
  logic [KEEP_WIDTH-1:0]  tx_tkeep_c;

  rx_state_e              rx_state_q, rx_state_d;
  logic [111:0]           rx_hdr_q, rx_hdr_d;
  logic [PAY_W-1:0]       rx_buf_q, rx_buf_d;
  logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;
  logic                   rx_user_q, rx_user_d;
  logic                   rx_hdr_ready_q, rx_hdr_ready_d;
  logic                   rx_tready_q, rx_tready_d;
  logic                   rx_valid_q, rx_valid_d;
  int unsigned            rx_keep_n_c;
`ifdef FLAT_FRAME_LEN_CHECK_EN
  logic [15:0]            rx_len_q, rx_len_d;
  logic                   rx_len_err_q, rx_len_err_d;
`endif

  // TX state register
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q       <= TX_IDLE;
      tx_frame_q       <= '0;
      tx_beat_q        <= '0;
      tx_hdr_valid_q   <= 1'b0;
      tx_tvalid_q      <= 1'b0;
      tx_frame_ready_q <= 1'b0;
    end else begin
      tx_state_q       <= tx_state_d;
      tx_frame_q       <= tx_frame_d;
      tx_beat_q        <= tx_beat_d;
      tx_hdr_valid_q   <= tx_hdr_valid_d;
      tx_tvalid_q      <= tx_tvalid_d;
      tx_frame_ready_q <= tx_frame_ready_d;
    end
  end

  // TX next state: header and payload handshakes complete independently
  always_comb begin
    tx_state_d       = tx_state_q;
    tx_frame_d       = tx_frame_q;
    tx_beat_d        = tx_beat_q;
    tx_hdr_valid_d   = tx_hdr_valid_q;
    tx_tvalid_d      = tx_tvalid_q;
    tx_frame_ready_d = tx_frame_ready_q;
    tx_hdr_done_c    = 1'b0;
    tx_pay_done_c    = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_frame_ready_d = 1'b1;
        if (s_frame_valid && tx_frame_ready_q) begin
          tx_frame_d       = s_frame_data;
          tx_beat_d        = '0;
          tx_hdr_valid_d   = 1'b1;
          tx_tvalid_d      = 1'b1;
          tx_frame_ready_d = 1'b0;
          tx_state_d       = TX_SEND;
        end
      end
      TX_SEND: begin
        tx_hdr_done_c = !tx_hdr_valid_q || m_eth_hdr_ready;
        tx_pay_done_c = !tx_tvalid_q ||
                        (m_eth_payload_axis_tready && (tx_beat_q == LAST_BEAT));
        if (tx_hdr_valid_q && m_eth_hdr_ready) tx_hdr_valid_d = 1'b0;
        if (tx_tvalid_q && m_eth_payload_axis_tready) begin
          if (tx_beat_q == LAST_BEAT) tx_tvalid_d = 1'b0;
          else                        tx_beat_d   = tx_beat_q + 1'b1;
        end
        if (tx_hdr_done_c && tx_pay_done_c) begin
          tx_state_d       = TX_IDLE;
          tx_frame_ready_d = 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX beat slicing: lane 0 carries the earliest payload byte
  always_comb begin
    tx_tdata_c = '0;
    tx_tkeep_c = '0;
    for (int unsigned j = 0; j < KEEP_WIDTH; j++) begin
      if (32'(tx_beat_q) * KEEP_WIDTH + j < PAYLOAD_BYTES) begin
        tx_tdata_c[8*j +: 8] =
          tx_frame_q[8*(PAYLOAD_BYTES - 1 - (32'(tx_beat_q) * KEEP_WIDTH + j)) +: 8];
        tx_tkeep_c[j] = tx_tvalid_q;
      end
    end
  end

  assign s_frame_ready             = tx_frame_ready_q;
  assign m_eth_hdr_valid           = tx_hdr_valid_q;
  assign m_eth_dest_mac            = tx_frame_q[FRAME_WIDTH-1 -: 48];
  assign m_eth_src_mac             = tx_frame_q[FRAME_WIDTH-49 -: 48];
  assign m_eth_type                = tx_frame_q[FRAME_WIDTH-97 -: 16];
  assign m_eth_payload_axis_tdata  = tx_tdata_c;
  assign m_eth_payload_axis_tkeep  = tx_tkeep_c;
  assign m_eth_payload_axis_tvalid = tx_tvalid_q;
  assign m_eth_payload_axis_tlast  = tx_tvalid_q && (tx_beat_q == LAST_BEAT);
  assign m_eth_payload_axis_tuser  = 1'b0;

  // RX state register
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q     <= RX_HDR;
      rx_hdr_q       <= '0;
      rx_buf_q       <= '0;
      rx_cnt_q       <= '0;
      rx_user_q      <= 1'b0;
      rx_hdr_ready_q <= 1'b0;
      rx_tready_q    <= 1'b0;
      rx_valid_q     <= 1'b0;
`ifdef FLAT_FRAME_LEN_CHECK_EN
      rx_len_q       <= '0;
      rx_len_err_q   <= 1'b0;
`endif
    end else begin
      rx_state_q     <= rx_state_d;
      rx_hdr_q       <= rx_hdr_d;
      rx_buf_q       <= rx_buf_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_user_q      <= rx_user_d;
      rx_hdr_ready_q <= rx_hdr_ready_d;
      rx_tready_q    <= rx_tready_d;
      rx_valid_q     <= rx_valid_d;
`ifdef FLAT_FRAME_LEN_CHECK_EN
      rx_len_q       <= rx_len_d;
      rx_len_err_q   <= rx_len_err_d;
`endif
    end
  end

  // Number of contiguous low bytes enabled by tkeep on the current RX beat
  always_comb begin
    rx_keep_n_c = 0;
    for (int unsigned j = 0; j < KEEP_WIDTH; j++) begin
      if (s_eth_payload_axis_tkeep[j] && (rx_keep_n_c == j)) rx_keep_n_c = j + 1;
    end
  end

  // RX next state: gather beats into the byte buffer, then present the frame
  always_comb begin
    rx_state_d     = rx_state_q;
    rx_hdr_d       = rx_hdr_q;
    rx_buf_d       = rx_buf_q;
    rx_cnt_d       = rx_cnt_q;
    rx_user_d      = rx_user_q;
    rx_hdr_ready_d = rx_hdr_ready_q;
    rx_tready_d    = rx_tready_q;
    rx_valid_d     = rx_valid_q;
`ifdef FLAT_FRAME_LEN_CHECK_EN
    rx_len_d       = rx_len_q;
    rx_len_err_d   = rx_len_err_q;
`endif
    case (rx_state_q)
      RX_HDR: begin
        rx_hdr_ready_d = 1'b1;
        if (s_eth_hdr_valid && rx_hdr_ready_q) begin
          rx_hdr_d       = {s_eth_dest_mac, s_eth_src_mac, s_eth_type};
          rx_buf_d       = '0;
          rx_cnt_d       = '0;
          rx_user_d      = 1'b0;
          rx_hdr_ready_d = 1'b0;
          rx_tready_d    = 1'b1;
          rx_state_d     = RX_PAYLOAD;
`ifdef FLAT_FRAME_LEN_CHECK_EN
          rx_len_d       = '0;
`endif
        end
      end
      RX_PAYLOAD: begin
        if (s_eth_payload_axis_tvalid && rx_tready_q) begin
          for (int unsigned j = 0; j < KEEP_WIDTH; j++) begin
            if ((j < rx_keep_n_c) && (32'(rx_cnt_q) + j < PAYLOAD_BYTES)) begin
              rx_buf_d[8*(PAYLOAD_BYTES - 1 - (32'(rx_cnt_q) + j)) +: 8] =
                s_eth_payload_axis_tdata[8*j +: 8];
            end
          end
          if (32'(rx_cnt_q) + rx_keep_n_c >= PAYLOAD_BYTES) rx_cnt_d = CNT_W'(PAYLOAD_BYTES);
          else rx_cnt_d = CNT_W'(32'(rx_cnt_q) + rx_keep_n_c);
          rx_user_d = rx_user_q | s_eth_payload_axis_tuser;
`ifdef FLAT_FRAME_LEN_CHECK_EN
          rx_len_d  = rx_len_q + 16'(rx_keep_n_c);
`endif
          if (s_eth_payload_axis_tlast) begin
            rx_tready_d = 1'b0;
            rx_valid_d  = 1'b1;
            rx_state_d  = RX_OUT;
`ifdef FLAT_FRAME_LEN_CHECK_EN
            rx_len_err_d = (rx_len_d != 16'(PAYLOAD_BYTES));
`else
            // short frames stay zero-padded, long frames are truncated silently
`endif
          end
        end
      end
      RX_OUT: begin
        if (m_frame_ready && rx_valid_q) begin
          rx_valid_d     = 1'b0;
          rx_hdr_ready_d = 1'b1;
          rx_state_d     = RX_HDR;
`ifdef FLAT_FRAME_LEN_CHECK_EN
          rx_len_err_d   = 1'b0;
`endif
        end
      end
      default: rx_state_d = RX_HDR;
    endcase
  end

  assign s_eth_hdr_ready           = rx_hdr_ready_q;
  assign s_eth_payload_axis_tready = rx_tready_q;
  assign m_frame_valid             = rx_valid_q;
  assign m_frame_data              = {rx_hdr_q, rx_buf_q};
  assign m_frame_user              = rx_user_q;
`ifdef FLAT_FRAME_LEN_CHECK_EN
  assign m_frame_len_error         = rx_len_err_q;
`endif

endmodule

// File: tb/tb_eth_flat_frame_bridge.sv
// Randomized self-checking bench for eth_flat_frame_bridge (64-bit datapath).
module tb_eth_flat_frame_bridge;
  localparam int DW    = 64;
  localparam int KW    = DW / 8;
  localparam int PB    = 28;
  localparam int FW    = 112 + 8 * PB;
  localparam int BEATS = (PB + KW - 1) / KW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          s_frame_valid, s_frame_ready;
  logic [FW-1:0] s_frame_data;
  logic          m_eth_hdr_valid, m_eth_hdr_ready;
  logic [47:0]   m_eth_dest_mac, m_eth_src_mac;
  logic [15:0]   m_eth_type;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid, m_tready, m_tlast, m_tuser;
  logic          s_eth_hdr_valid, s_eth_hdr_ready;
  logic [47:0]   s_eth_dest_mac, s_eth_src_mac;
  logic [15:0]   s_eth_type;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tvalid, s_tready, s_tlast, s_tuser;
  logic          m_frame_valid, m_frame_ready, m_frame_user;
  logic [FW-1:0] m_frame_data;
`ifdef FLAT_FRAME_LEN_CHECK_EN
  logic          m_frame_len_error;
`endif

  eth_flat_frame_bridge #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .PAYLOAD_BYTES(PB)) dut (
    .clk(clk), .rst(rst),
    .s_frame_valid(s_frame_valid), .s_frame_ready(s_frame_ready), .s_frame_data(s_frame_data),
    .m_eth_hdr_valid(m_eth_hdr_valid), .m_eth_hdr_ready(m_eth_hdr_ready),
    .m_eth_dest_mac(m_eth_dest_mac), .m_eth_src_mac(m_eth_src_mac), .m_eth_type(m_eth_type),
    .m_eth_payload_axis_tdata(m_tdata), .m_eth_payload_axis_tkeep(m_tkeep),
    .m_eth_payload_axis_tvalid(m_tvalid), .m_eth_payload_axis_tready(m_tready),
    .m_eth_payload_axis_tlast(m_tlast), .m_eth_payload_axis_tuser(m_tuser),
    .s_eth_hdr_valid(s_eth_hdr_valid), .s_eth_hdr_ready(s_eth_hdr_ready),
    .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
    .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tkeep(s_tkeep),
    .s_eth_payload_axis_tvalid(s_tvalid), .s_eth_payload_axis_tready(s_tready),
    .s_eth_payload_axis_tlast(s_tlast), .s_eth_payload_axis_tuser(s_tuser),
    .m_frame_valid(m_frame_valid), .m_frame_ready(m_frame_ready),
    .m_frame_data(m_frame_data), .m_frame_user(m_frame_user)
`ifdef FLAT_FRAME_LEN_CHECK_EN
    ,.m_frame_len_error(m_frame_len_error)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] lb_d[$];
  logic [KW-1:0] lb_k[$];
  logic [111:0]  lb_hdr;
  logic [DW-1:0] rx_d[$];
  logic [KW-1:0] rx_k[$];
  logic          rx_u[$];

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Payload byte i of a flat frame (byte 0 right below the type field)
  function automatic logic [7:0] pay_byte(input logic [FW-1:0] f, input int i);
    return f[FW-113-8*i -: 8];
  endfunction

  function automatic logic [DW-1:0] ref_tdata(input logic [FW-1:0] f, input int b);
    logic [DW-1:0] d;
    d = '0;
    for (int j = 0; j < KW; j++) if (b * KW + j < PB) d[8*j +: 8] = pay_byte(f, b * KW + j);
    return d;
  endfunction

  function automatic logic [KW-1:0] ref_tkeep(input int b);
    logic [KW-1:0] k;
    k = '0;
    for (int j = 0; j < KW; j++) k[j] = (b * KW + j < PB);
    return k;
  endfunction

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int i = 0; i < FW / 8; i++) f[8*i +: 8] = 8'($urandom);
    return f;
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] d;
    for (int j = 0; j < KW; j++) d[8*j +: 8] = 8'($urandom);
    return d;
  endfunction

  function automatic logic [KW-1:0] low_mask(input int n);
    logic [KW-1:0] k;
    k = '0;
    for (int j = 0; j < n; j++) k[j] = 1'b1;
    return k;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_frdy"}, 512'(s_frame_ready), 512'(0));
    chk({tag, "_hvld"}, 512'(m_eth_hdr_valid), 512'(0));
    chk({tag, "_tvld"}, 512'(m_tvalid), 512'(0));
    chk({tag, "_txout"}, 512'({m_tdata, m_tkeep, m_tlast, m_tuser, m_eth_dest_mac, m_eth_type}), 512'(0));
    chk({tag, "_hrdy"}, 512'(s_eth_hdr_ready), 512'(0));
    chk({tag, "_trdy"}, 512'(s_tready), 512'(0));
    chk({tag, "_fvld"}, 512'(m_frame_valid), 512'(0));
    chk({tag, "_fdata"}, 512'({m_frame_data, m_frame_user}), 512'(0));
`ifdef FLAT_FRAME_LEN_CHECK_EN
    chk({tag, "_lenerr"}, 512'(m_frame_len_error), 512'(0));
`endif
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    s_frame_valid = 1'b0; m_eth_hdr_ready = 1'b0; m_tready = 1'b0;
    s_eth_hdr_valid = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; m_frame_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Send a flat frame; rdy_mode 0: tready=1, 1: toggling, 2: random
  task automatic tx_frame(input logic [FW-1:0] f, input int hdr_stall, input int rdy_mode,
                          input int abort_at);
    int cyc, beats;
    bit hdr_done;
    lb_d.delete(); lb_k.delete();
    cyc = 0;
    while (!s_frame_ready && cyc < 100) begin @(negedge clk); cyc++; end
    chk("tx_idle_ready", 512'(s_frame_ready), 512'(1));
    s_frame_valid = 1'b1; s_frame_data = f;
    @(negedge clk);
    s_frame_valid = 1'b0; s_frame_data = '0;
    chk("tx_hdr_latency", 512'(m_eth_hdr_valid), 512'(1));
    chk("tx_beat_latency", 512'(m_tvalid), 512'(1));
    chk("tx_hdr_fields", 512'({m_eth_dest_mac, m_eth_src_mac, m_eth_type}), 512'(f[FW-1 -: 112]));
    beats = 0; hdr_done = 0; cyc = 0;
    while (!(hdr_done && beats == BEATS) && cyc < 1000) begin
      if (beats == abort_at) begin
        pulse_reset();
        chk_reset("tx_abort");
        return;
      end
      m_eth_hdr_ready = (cyc >= hdr_stall);
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = (cyc % 2 == 0);
        default: m_tready = 1'($urandom % 2);
      endcase
      if (beats < BEATS) chk("tx_tvalid_hold", 512'(m_tvalid), 512'(1));
      if (hdr_done) chk("tx_hdr_drop", 512'(m_eth_hdr_valid), 512'(0));
      chk("tx_busy_ready", 512'(s_frame_ready), 512'(0));
      if (m_tvalid && m_tready) begin
        chk("tx_tdata", 512'(m_tdata), 512'(ref_tdata(f, beats)));
        chk("tx_tkeep", 512'(m_tkeep), 512'(ref_tkeep(beats)));
        chk("tx_tlast_tuser", 512'({m_tlast, m_tuser}), 512'({beats == BEATS - 1, 1'b0}));
        lb_d.push_back(m_tdata); lb_k.push_back(m_tkeep);
        beats++;
      end
      if (m_eth_hdr_valid && m_eth_hdr_ready) begin
        hdr_done = 1;
        lb_hdr = {m_eth_dest_mac, m_eth_src_mac, m_eth_type};
      end
      @(negedge clk);
      cyc++;
    end
    m_eth_hdr_ready = 1'b0; m_tready = 1'b0;
    chk("tx_complete", 512'({hdr_done, beats == BEATS}), 512'(2'b11));
    chk("tx_back_idle", 512'({s_frame_ready, m_eth_hdr_valid, m_tvalid}), 512'(3'b100));
  endtask

  // Receive header + beats from rx_d/rx_k/rx_u, check the assembled frame
  task automatic rx_frame(input logic [111:0] hdr, input int hold, input int abort_at,
                          output logic [FW-1:0] got);
    int cyc, i, nb;
    logic [7:0] bytes[$];
    logic [FW-1:0] exp_f;
    logic exp_user;
    got = '0;
    nb = rx_d.size();
    exp_user = 1'b0;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < KW; j++) if (rx_k[b][j]) bytes.push_back(rx_d[b][8*j +: 8]);
      exp_user |= rx_u[b];
    end
    exp_f = '0;
    exp_f[FW-1 -: 112] = hdr;
    for (int p = 0; p < PB && p < bytes.size(); p++) exp_f[FW-113-8*p -: 8] = bytes[p];
    m_frame_ready = 1'b0;
    s_eth_hdr_valid = 1'b1;
    {s_eth_dest_mac, s_eth_src_mac, s_eth_type} = hdr;
    cyc = 0;
    while (!s_eth_hdr_ready && cyc < 100) begin @(negedge clk); cyc++; end
    chk("rx_hdr_ready", 512'(s_eth_hdr_ready), 512'(1));
    @(negedge clk);
    s_eth_hdr_valid = 1'b0;
    chk("rx_after_hdr", 512'({s_eth_hdr_ready, s_tready}), 512'(2'b01));
    i = 0; cyc = 0;
    while (i < nb && cyc < 1000) begin
      if (i == abort_at) begin
        pulse_reset();
        chk_reset("rx_abort");
        return;
      end
      if ($urandom % 4 == 0) s_tvalid = 1'b0;
      else begin
        s_tvalid = 1'b1; s_tdata = rx_d[i]; s_tkeep = rx_k[i];
        s_tuser = rx_u[i]; s_tlast = (i == nb - 1);
      end
      if (s_tvalid && s_tready) i++;
      @(negedge clk);
      cyc++;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    chk("rx_all_beats", 512'(i), 512'(nb));
    cyc = 0;
    while (!m_frame_valid && cyc < 20) begin @(negedge clk); cyc++; end
    chk("rx_frame_valid", 512'(m_frame_valid), 512'(1));
    chk("rx_frame_data", 512'(m_frame_data), 512'(exp_f));
    chk("rx_frame_user", 512'(m_frame_user), 512'(exp_user));
`ifdef FLAT_FRAME_LEN_CHECK_EN
    chk("rx_len_error", 512'(m_frame_len_error), 512'(bytes.size() != PB));
`endif
    chk("rx_out_readies", 512'({s_eth_hdr_ready, s_tready}), 512'(0));
    got = m_frame_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("rx_hold_valid", 512'(m_frame_valid), 512'(1));
      chk("rx_hold_data", 512'(m_frame_data), 512'(exp_f));
    end
    m_frame_ready = 1'b1;
    @(negedge clk);
    m_frame_ready = 1'b0;
    chk("rx_released", 512'({m_frame_valid, s_eth_hdr_ready}), 512'(2'b01));
`ifdef FLAT_FRAME_LEN_CHECK_EN
    chk("rx_len_err_clr", 512'(m_frame_len_error), 512'(0));
`endif
  endtask

  task automatic load_loopback();
    rx_d.delete(); rx_k.delete(); rx_u.delete();
    foreach (lb_d[b]) begin rx_d.push_back(lb_d[b]); rx_k.push_back(lb_k[b]); rx_u.push_back(1'b0); end
  endtask

  task automatic load_rx(input logic [KW-1:0] keeps[$], input int user_beat);
    rx_d.delete(); rx_k.delete(); rx_u.delete();
    foreach (keeps[b]) begin
      rx_d.push_back(rand_beat()); rx_k.push_back(keeps[b]); rx_u.push_back(b == user_beat);
    end
  endtask

  task automatic load_rx_random();
    int nb, r;
    rx_d.delete(); rx_k.delete(); rx_u.delete();
    nb = 1 + $urandom % 6;
    for (int b = 0; b < nb; b++) begin
      r = $urandom % 8;
      rx_d.push_back(rand_beat());
      if (r == 0)      rx_k.push_back('0);
      else if (r == 1) rx_k.push_back(low_mask(1 + $urandom % KW));
      else             rx_k.push_back('1);
      rx_u.push_back($urandom % 8 == 0);
    end
  endtask

  logic [FW-1:0] f0, f, got;
  logic [KW-1:0] keeps[$];

  initial begin
    s_frame_valid = 0; s_frame_data = '0; m_eth_hdr_ready = 0; m_tready = 0;
    s_eth_hdr_valid = 0; s_eth_dest_mac = '0; s_eth_src_mac = '0; s_eth_type = '0;
    s_tdata = '0; s_tkeep = '0; s_tvalid = 0; s_tlast = 0; s_tuser = 0; m_frame_ready = 0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    f0 = {48'hffff_ffff_ffff, 48'h5a51_5253_5455, 16'h0806,
          224'h0001_0800_0604_0001_5a51_5253_5455_c0a8_0164_0000_0000_0000_c0a8_0165};
    tx_frame(f0, 0, 0, -1);
    chk("arp_beat0", 512'(lb_d[0]), 512'(64'h0100_0406_0008_0100));
    chk("arp_last_keep", 512'(lb_k[BEATS-1]), 512'(8'h0f));
    load_loopback();
    rx_frame(lb_hdr, 0, -1, got);
    chk("loopback_frame", 512'(got), 512'(f0));

    tx_frame(f0, 5, 1, -1);
    load_loopback();
    rx_frame(lb_hdr, 2, -1, got);
    chk("loopback_bp_frame", 512'(got), 512'(f0));

    keeps = '{8'hff, 8'hff, 8'h0f};
    load_rx(keeps, 2);
    rx_frame(112'h0102_0304_0506_0a0b_0c0d_0e0f_0800, 4, -1, got);

    keeps = '{8'hff, 8'h00, 8'hff, 8'hff, 8'hff, 8'hff};
    load_rx(keeps, -1);
    rx_frame(112'hffff_ffff_ffff_1111_2222_3333_86dd, 1, -1, got);

    for (int it = 0; it < 25; it++) begin
      f = rand_frame();
      tx_frame(f, $urandom % 6, 2, -1);
      load_loopback();
      rx_frame(lb_hdr, $urandom % 3, -1, got);
      chk("loopback_rand", 512'(got), 512'(f));
      load_rx_random();
      rx_frame({$urandom, $urandom, $urandom, 16'($urandom)}, $urandom % 3, -1, got);
    end

    tx_frame(rand_frame(), 0, 0, BEATS / 2);
    f = rand_frame();
    tx_frame(f, 1, 0, -1);
    load_loopback();
    rx_frame(lb_hdr, 0, 2, got);
    rx_frame(lb_hdr, 0, -1, got);
    chk("after_abort_frame", 512'(got), 512'(f));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
